// File: rtl/md_io_ports_pkg.sv
// Shared register map, reset values and per-port register struct for the
// MegaDrive I/O register block ($A10001-$A1001F).
package md_io_pkg;

  localparam int NUM_PORTS = 3;

  localparam logic [3:0] REG_VERSION = 4'h0;
  localparam logic [3:0] REG_DATA1   = 4'h1;
  localparam logic [3:0] REG_DATA2   = 4'h2;
  localparam logic [3:0] REG_DATA3   = 4'h3;
  localparam logic [3:0] REG_CTRL1   = 4'h4;
  localparam logic [3:0] REG_CTRL2   = 4'h5;
  localparam logic [3:0] REG_CTRL3   = 4'h6;
  localparam logic [3:0] REG_TX1     = 4'h7;
  localparam logic [3:0] REG_RX1     = 4'h8;
  localparam logic [3:0] REG_SCTRL1  = 4'h9;
  localparam logic [3:0] REG_TX2     = 4'hA;
  localparam logic [3:0] REG_RX2     = 4'hB;
  localparam logic [3:0] REG_SCTRL2  = 4'hC;
  localparam logic [3:0] REG_TX3     = 4'hD;
  localparam logic [3:0] REG_RX3     = 4'hE;
  localparam logic [3:0] REG_SCTRL3  = 4'hF;

  localparam logic [7:0] DATA_RST  = 8'h00;
  localparam logic [7:0] CTRL_RST  = 8'h00;
  localparam logic [7:0] TX_RST    = 8'hFF;
  localparam logic [7:0] SCTRL_RST = 8'h00;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] ctrl;
    logic [7:0] tx;
    logic [7:0] sctrl;
  } port_regs_t;

  // Serial registers sit in tx/rx/sctrl triplets starting at REG_TX1.
  function automatic logic [3:0] data_addr(int p);
    return REG_DATA1 + 4'(p);
  endfunction
  function automatic logic [3:0] ctrl_addr(int p);
    return REG_CTRL1 + 4'(p);
  endfunction
  function automatic logic [3:0] tx_addr(int p);
    return REG_TX1 + 4'(3 * p);
  endfunction
  function automatic logic [3:0] sctrl_addr(int p);
    return REG_SCTRL1 + 4'(3 * p);
  endfunction

endpackage

// File: rtl/md_io_ports_if.sv
// CPU-side register bus for the I/O block: one-cycle strobe, registered ack.
interface md_io_ports_if;
  logic       sel;
  logic       we;
  logic       lds_n;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dtack;

  modport master (output sel, we, lds_n, addr, din, input dout, dtack);
  modport slave  (input sel, we, lds_n, addr, din, output dout, dtack);
endinterface

// File: rtl/md_io_ports_port.sv
// One controller port: data/ctrl/tx/sctrl registers, pin read-back and the
// TH falling-edge detector (only built with MD_IO_THINT_EN).
module md_io_port
  import md_io_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_data,
  input  logic       wr_ctrl,
  input  logic       wr_tx,
  input  logic       wr_sctrl,
  input  logic [7:0] din,
  input  logic [6:0] pin,
  output port_regs_t regs,
  output logic [7:0] data_rd,
  output logic       th_event
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs <= '{data: DATA_RST, ctrl: CTRL_RST, tx: TX_RST, sctrl: SCTRL_RST};
    end else begin
      if (wr_data)  regs.data  <= din;
      if (wr_ctrl)  regs.ctrl  <= din;
      if (wr_tx)    regs.tx    <= din;
      // Status bits 2:0 are hardwired: no rx ready, tx empty, no error.
      if (wr_sctrl) regs.sctrl <= {din[7:3], 3'b000};
    end
  end

  assign data_rd = {regs.data[7], pin};

`ifdef MD_IO_THINT_EN
  logic th_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) th_d <= 1'b0;
    else          th_d <= pin[6];
  end

  // Only a TH pin configured as input with interrupts enabled can fire.
  assign th_event = th_d & ~pin[6] & regs.ctrl[7] & ~regs.ctrl[6];
`else
  assign th_event = 1'b0;
`endif

endmodule

// File: rtl/md_io_ports.sv
// MegaDrive I/O chip CPU register block: decode, read mux, ack and HL pulse.
// Optional TH interrupt generation is enabled by defining MD_IO_THINT_EN.
module md_io_ports
  import md_io_pkg::*;
#(
  parameter logic [3:0] VERSION  = 4'h0,
  parameter int         HL_PULSE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  md_io_ports_if.slave bus,
  input  logic       pal,
  input  logic       export_reg,
  input  logic [6:0] p1_pin,
  input  logic [6:0] p2_pin,
  input  logic [6:0] p3_pin,
  output logic [6:0] p1_data,
  output logic [6:0] p2_data,
  output logic [6:0] p3_data,
  output logic [6:0] p1_dir,
  output logic [6:0] p2_dir,
  output logic [6:0] p3_dir,
  output logic       hl_n
);

  logic                           wr;
  logic [NUM_PORTS-1:0][6:0]      pin_a;
  port_regs_t [NUM_PORTS-1:0]     regs;
  logic [NUM_PORTS-1:0][7:0]      data_rd;
  logic [NUM_PORTS-1:0]           th_ev;
  logic [7:0]                     rdata;
  logic [7:0]                     dout_q;
  logic                           dtack_q;

  assign wr    = bus.sel & bus.we & ~bus.lds_n;
  assign pin_a = {p3_pin, p2_pin, p1_pin};

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    md_io_port u_port (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_data  (wr && bus.addr == data_addr(gi)),
      .wr_ctrl  (wr && bus.addr == ctrl_addr(gi)),
      .wr_tx    (wr && bus.addr == tx_addr(gi)),
      .wr_sctrl (wr && bus.addr == sctrl_addr(gi)),
      .din      (bus.din),
      .pin      (pin_a[gi]),
      .regs     (regs[gi]),
      .data_rd  (data_rd[gi]),
      .th_event (th_ev[gi])
    );
  end

  assign p1_data = regs[0].data[6:0];
  assign p2_data = regs[1].data[6:0];
  assign p3_data = regs[2].data[6:0];
  assign p1_dir  = regs[0].ctrl[6:0];
  assign p2_dir  = regs[1].ctrl[6:0];
  assign p3_dir  = regs[2].ctrl[6:0];

  always_comb begin
    rdata = 8'h00;
    case (bus.addr)
      REG_VERSION:               rdata = {export_reg, pal, 2'b10, VERSION};
      REG_DATA1:                 rdata = data_rd[0];
      REG_DATA2:                 rdata = data_rd[1];
      REG_DATA3:                 rdata = data_rd[2];
      REG_CTRL1:                 rdata = regs[0].ctrl;
      REG_CTRL2:                 rdata = regs[1].ctrl;
      REG_CTRL3:                 rdata = regs[2].ctrl;
      REG_TX1:                   rdata = regs[0].tx;
      REG_TX2:                   rdata = regs[1].tx;
      REG_TX3:                   rdata = regs[2].tx;
      REG_RX1, REG_RX2, REG_RX3: rdata = 8'hFF;
      REG_SCTRL1:                rdata = regs[0].sctrl;
      REG_SCTRL2:                rdata = regs[1].sctrl;
      REG_SCTRL3:                rdata = regs[2].sctrl;
      default:                   rdata = 8'h00;
    endcase
  end

  // Read data is captured from pre-write state; dout holds until the next read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q  <= 8'h00;
      dtack_q <= 1'b0;
    end else begin
      dtack_q <= bus.sel;
      if (bus.sel && !bus.we) dout_q <= rdata;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.dtack = dtack_q;

`ifdef MD_IO_THINT_EN
  logic [7:0] hl_cnt;

  // Any new event reloads the full pulse width; events are never queued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hl_cnt <= 8'd0;
      hl_n   <= 1'b1;
    end else if (|th_ev) begin
      hl_cnt <= 8'(HL_PULSE);
      hl_n   <= 1'b0;
    end else if (hl_cnt != 8'd0) begin
      hl_cnt <= hl_cnt - 8'd1;
      if (hl_cnt == 8'd1) hl_n <= 1'b1;
    end
  end
`else
  logic unused_th_ev;
  assign unused_th_ev = |th_ev;
  assign hl_n         = 1'b1;
`endif

endmodule
